prog_loader: RTL
================

# prog_loader

Program loader and instruction encoder for the 8-bit core. It is the write-side counterpart of the control unit's fetch/decode path. It accepts decoded instruction fields over a valid/ready handshake and packs them into the 16-bit instruction format that the control unit decodes. It then writes each packed word into instruction memory at consecutive addresses, starting from a programmable base address.

## Interface
- DEPTH, 256: maximum words per load session (1..256).
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; opens a session (honoured in IDLE, DONE, ERR only).
- base_addr  in  8  first instruction address; latched on start.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  loader can accept.
- in_op  in  5  opcode.
- in_rd  in  2  destination register.
- in_rs1  in  2  source register A.
- in_rs2  in  2  source register B.
- in_imm  in  8  immediate, memory address or label.
- in_last  in  1  final instruction of program.
- im_we  out  1  instruction-memory write strobe.
- im_addr  out  8  write address.
- im_wdata  out  16  encoded instruction.
- busy  out  1  state is RUN.
- done  out  1  one-cycle pulse on normal completion.
- err_code  out  2  00 none, 01 illegal opcode, 10 overflow; sticky until start or reset.
- count  out  9  words written in the current session.

## Operation
- States:
  - IDLE: start -> RUN, with wp=base_addr, count=0, err_code=00.
  - RUN: in_ready=1.
  - DONE: done=1 for one cycle -> IDLE.
  - ERR: holds until start.
- start while in RUN is ignored.
- Accept = in_valid & in_ready. Fields are sampled only on accept.
- Encoding by field class. Unused bits are 0. Register fields: rd=[9:8], rs1=[5:4], rs2=[1:0], imm=[7:0].
  - Three registers: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100 -> {op,1'b0,rd,2'b00,rs1,2'b00,rs2}.
  - Two registers: INV 00101, SHL 00110, MOV 00111, SHR 10010 -> same layout, rs2 forced to 0.
  - Register only: INC 01010, DEC 01011 -> {op,1'b0,rd,8'h00}.
  - Register + immediate: LOAD 01000, JNZ 01110, LDM 10000, STM 10001 -> {op,1'b0,rd,imm}.
  - Label only: JZ 01001, JC 01101, JMP 01111 -> {op,3'b000,imm}.
  - HLT 01100 -> {op,11'b0}.
- Any other opcode is illegal:
  - Handshake completes, but nothing is written and count is unchanged.
  - err_code=01; state -> ERR.
- Legal accept: word is written at wp; wp <= wp+1, wrapping 8'hFF -> 8'h00; count <= count+1.
- in_last on a legal accept: the word is written, then state -> DONE.
- Overflow: on accepting the DEPTH-th legal word without in_last, the word is written, err_code=10, and state -> ERR.
- Illegal takes priority over in_last and overflow.
- Reset or start mid-session discards any pending write.

## Timing
- Reset: state IDLE; in_ready, im_we, busy, done = 0; im_addr, im_wdata = 0; err_code=00; count=0.
- in_ready is combinational from state only: high exactly while in RUN, so throughput is one word per cycle.
- Accept at edge N -> im_we=1 with valid im_addr/im_wdata during cycle N+1 (registered). im_we is 0 otherwise; im_addr/im_wdata hold their last values.
- Terminating accept at edge N: state, done and err_code update at N+1 together with the final im_we. in_ready is low from N+1.
- start at edge N -> busy and in_ready high from N+1.

## Configuration
- PROG_LOADER_HLT_STOP_EN defined: an accepted HLT is treated as in_last=1, so the session ends in DONE after HLT is written.
- Undefined: HLT is an ordinary word; only in_last or an error ends the session.

## Test plan
- start base=8'h10; send ADD rd1,rs1 2,rs2 3, then LOAD r2,8'h5A with last -> writes 16'h0123@8'h10, 16'h425A@8'h11; done pulse; count=2.
- Back-to-back MOV r0<-r2, INC r1, JNZ r3,8'h04, JMP 8'h10 (last) at full rate -> 16'h3820, 16'h5100, 16'h7304, 16'h7810 on four consecutive cycles.
- base=8'hFE, three words -> addresses FE, FF, 00.
- Opcode 5'b11111 as the second word -> one write only; err_code=01; in_ready low until start, which clears err_code.
- DEPTH=4, five words offered, none with last -> four writes; err_code=10; fifth word is not accepted.
- HLT mid-stream -> 16'h6000 written; with the macro the session ends in DONE; without it the session stays in RUN. rst_n low mid-session -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/prog_loader_if.sv
// Loader-side bundle: session control, instruction-field stream, memory write port
// and status. The slave modport is the loader's view.
interface prog_loader_if;
   logic        start;
   logic [7:0]  base_addr;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_op;
   logic [1:0]  in_rd;
   logic [1:0]  in_rs1;
   logic [1:0]  in_rs2;
   logic [7:0]  in_imm;
   logic        in_last;
   logic        im_we;
   logic [7:0]  im_addr;
   logic [15:0] im_wdata;
   logic        busy;
   logic        done;
   logic [1:0]  err_code;
   logic [8:0]  count;

   modport slave (
      input  start, base_addr, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
      output in_ready, im_we, im_addr, im_wdata, busy, done, err_code, count
   );

   modport master (
      output start, base_addr, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last,
      input  in_ready, im_we, im_addr, im_wdata, busy, done, err_code, count
   );
endinterface

// File: rtl/prog_loader.sv
// Packs decoded instruction fields into 16-bit words and writes them to instruction memory.
// Optional macro PROG_LOADER_HLT_STOP_EN: an accepted HLT also closes the session.
module prog_loader #(
   parameter int DEPTH = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   prog_loader_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00010;
   localparam logic [4:0] OP_OR   = 5'b00011;
   localparam logic [4:0] OP_XOR  = 5'b00100;
   localparam logic [4:0] OP_INV  = 5'b00101;
   localparam logic [4:0] OP_SHL  = 5'b00110;
   localparam logic [4:0] OP_MOV  = 5'b00111;
   localparam logic [4:0] OP_LOAD = 5'b01000;
   localparam logic [4:0] OP_JZ   = 5'b01001;
   localparam logic [4:0] OP_INC  = 5'b01010;
   localparam logic [4:0] OP_DEC  = 5'b01011;
   localparam logic [4:0] OP_HLT  = 5'b01100;
   localparam logic [4:0] OP_JC   = 5'b01101;
   localparam logic [4:0] OP_JNZ  = 5'b01110;
   localparam logic [4:0] OP_JMP  = 5'b01111;
   localparam logic [4:0] OP_LDM  = 5'b10000;
   localparam logic [4:0] OP_STM  = 5'b10001;
   localparam logic [4:0] OP_SHR  = 5'b10010;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
   localparam logic [1:0] ERR_OVERFLOW = 2'b10;

   localparam logic [8:0] COUNT_LAST = 9'(DEPTH - 1);

   state_t      state_q, state_d;
   logic [7:0]  wp_q, wp_d;
   logic [8:0]  count_q, count_d;
   logic [1:0]  err_q, err_d;
   logic        we_q, we_d;
   logic [7:0]  addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;

   logic        accept;
   logic        legal;
   logic        is_last;
   logic [15:0] enc;

   assign accept = bus.in_valid && (state_q == S_RUN);

`ifdef PROG_LOADER_HLT_STOP_EN
   assign is_last = bus.in_last || (bus.in_op == OP_HLT);
`else
   assign is_last = bus.in_last;
`endif

   // Field-class encoder; fields outside an opcode's class are masked to zero.
   always_comb begin
      legal = 1'b1;
      enc   = 16'h0000;
      case (bus.in_op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
            enc = {bus.in_op, 1'b0, bus.in_rd, 2'b00, bus.in_rs1, 2'b00, bus.in_rs2};
         OP_INV, OP_SHL, OP_MOV, OP_SHR:
            enc = {bus.in_op, 1'b0, bus.in_rd, 2'b00, bus.in_rs1, 4'b0000};
         OP_INC, OP_DEC:
            enc = {bus.in_op, 1'b0, bus.in_rd, 8'h00};
         OP_LOAD, OP_JNZ, OP_LDM, OP_STM:
            enc = {bus.in_op, 1'b0, bus.in_rd, bus.in_imm};
         OP_JZ, OP_JC, OP_JMP:
            enc = {bus.in_op, 3'b000, bus.in_imm};
         OP_HLT:
            enc = {bus.in_op, 11'h000};
         default:
            legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      wp_d    = wp_q;
      count_d = count_q;
      err_d   = err_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      case (state_q)
         S_RUN: begin
            if (accept) begin
               if (!legal) begin
                  err_d   = ERR_ILLEGAL;
                  state_d = S_ERR;
               end else begin
                  we_d    = 1'b1;
                  addr_d  = wp_q;
                  wdata_d = enc;
                  wp_d    = wp_q + 8'd1;
                  count_d = count_q + 9'd1;
                  if (is_last) begin
                     state_d = S_DONE;
                  end else if (count_q == COUNT_LAST) begin
                     err_d   = ERR_OVERFLOW;
                     state_d = S_ERR;
                  end
               end
            end
         end
         default: begin
            // DONE is a single-cycle pulse unless a new session starts immediately.
            if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
            if (bus.start) begin
               state_d = S_RUN;
               wp_d    = bus.base_addr;
               count_d = 9'd0;
               err_d   = ERR_NONE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wp_q    <= 8'h00;
         count_q <= 9'd0;
         err_q   <= ERR_NONE;
         we_q    <= 1'b0;
         addr_q  <= 8'h00;
         wdata_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         wp_q    <= wp_d;
         count_q <= count_d;
         err_q   <= err_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign bus.in_ready = (state_q == S_RUN);
   assign bus.busy     = (state_q == S_RUN);
   assign bus.done     = (state_q == S_DONE);
   assign bus.im_we    = we_q;
   assign bus.im_addr  = addr_q;
   assign bus.im_wdata = wdata_q;
   assign bus.err_code = err_q;
   assign bus.count    = count_q;

endmodule
